read_memory_arbiter_pipelined: RTL and testbench

Parametrised N-port read arbiter for a single-port memory with configurable read latency. It selects between fixed-priority and round-robin grant policies. It allows at most one outstanding read per port and registers returned data in a per-port output slot. Data is never lost under consumer backpressure. It sits between load ports and the memory read interface, in place of the single-cycle, fixed-priority read arbiter.

---
 rtl/read_memory_arbiter_pipelined.sv | 87 ++++++++
 tb/tb_read_memory_arbiter_pipelined.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/read_memory_arbiter_pipelined.sv
// read_memory_arbiter_pipelined: N-port read arbiter for a fixed-latency single-port memory with fixed-priority or round-robin grant
module read_memory_arbiter_pipelined #(
  parameter int ARBITER_SIZE = 2,
  parameter int ADDR_TYPE = 32,
  parameter int DATA_TYPE = 32,
  parameter int READ_LATENCY = 1,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ARBITER_SIZE-1:0]           pValid,
  output logic [ARBITER_SIZE-1:0]           ready,
  input  logic [ARBITER_SIZE*ADDR_TYPE-1:0] address_in,
  input  logic [ARBITER_SIZE-1:0]           nReady,
  output logic [ARBITER_SIZE-1:0]           valid,
  output logic [ARBITER_SIZE*DATA_TYPE-1:0] data_out,
  output logic                              read_enable,
  output logic [ADDR_TYPE-1:0]              read_address,
  input  logic [DATA_TYPE-1:0]              data_from_memory
);
  localparam int N = ARBITER_SIZE;
  localparam int A = ADDR_TYPE;
  localparam int D = DATA_TYPE;
  localparam int L = READ_LATENCY;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  if (L < 1) begin : g_bad_latency
    $error("READ_LATENCY must be at least 1");
  end
  logic [N-1:0] pending_q, pending_d, valid_q, valid_d, eligible, grant;
  logic [N-1:0][D-1:0] out_q, out_d;
  logic [L-1:0] tag_v_q, tag_v_d;
  logic [L-1:0][IW-1:0] tag_id_q, tag_id_d;
  logic [IW-1:0] last_q, last_d, gidx, did;
  logic done;
  function automatic int pick(input int k, input logic [IW-1:0] last);
    return ROUND_ROBIN ? (int'(last) + 1 + k) % N : k;
  endfunction
  always_comb begin
    eligible = pValid & ~pending_q & (~valid_q | nReady);
    grant = '0;
    gidx = last_q;
    for (int k = 0; k < N; k++)
      if (!rst && grant == '0 && eligible[pick(k, last_q)]) begin
        grant[pick(k, last_q)] = 1'b1;
        gidx = IW'(pick(k, last_q));
      end
    ready = grant;
    read_enable = |grant;
    read_address = '0;
    for (int i = 0; i < N; i++)
      read_address = read_address | (grant[i] ? address_in[i*A +: A] : '0);
    last_d = read_enable ? gidx : last_q;
    done = tag_v_q[L-1];
    did = tag_id_q[L-1];
    tag_v_d[0] = read_enable;
    tag_id_d[0] = gidx;
    for (int k = 1; k < L; k++) begin
      tag_v_d[k] = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
    for (int i = 0; i < N; i++) begin
      pending_d[i] = grant[i] | (pending_q[i] & ~(done && did == IW'(i)));
      valid_d[i] = (done && did == IW'(i)) | (valid_q[i] & ~nReady[i]);
      out_d[i] = (done && did == IW'(i)) ? data_from_memory : out_q[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      valid_q <= '0;
      out_q <= '0;
      tag_v_q <= '0;
      tag_id_q <= '0;
      last_q <= IW'(N - 1);
    end else begin
      pending_q <= pending_d;
      valid_q <= valid_d;
      out_q <= out_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
      last_q <= last_d;
    end
  end
  assign valid = valid_q;
  assign data_out = out_q;
  assert property (@(posedge clk) disable iff (rst) !(done && valid_q[did] && !nReady[did]));
endmodule

// File: tb/tb_read_memory_arbiter_pipelined.sv
// tb_read_memory_arbiter_pipelined: directed scoreboard bench for fixed, round-robin and long-latency arbiter configurations
module tb_read_memory_arbiter_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [2:0] pv_f = '0, rdy_f, nr_f = '0, vld_f, pv_r = '0, rdy_r, nr_r = '0, vld_r;
  logic [95:0] ain_f = '0, dout_f, ain_r = '0, dout_r;
  logic [31:0] ra_f, dfm_f, ra_r, dfm_r, ra_3, dfm_3;
  logic re_f, re_r, re_3;
  logic [1:0] pv_3 = '0, rdy_3, nr_3 = '0, vld_3;
  logic [63:0] ain_3 = '0, dout_3;
  logic [31:0] mf_q, mr_q;
  logic [31:0] m3_q [3];
  logic [31:0] sb [9][$];
  read_memory_arbiter_pipelined #(.ARBITER_SIZE(3), .READ_LATENCY(1), .ROUND_ROBIN(1'b0)) u_f (
    .clk(clk), .rst(rst), .pValid(pv_f), .ready(rdy_f), .address_in(ain_f), .nReady(nr_f), .valid(vld_f),
    .data_out(dout_f), .read_enable(re_f), .read_address(ra_f), .data_from_memory(dfm_f));
  read_memory_arbiter_pipelined #(.ARBITER_SIZE(3), .READ_LATENCY(1), .ROUND_ROBIN(1'b1)) u_r (
    .clk(clk), .rst(rst), .pValid(pv_r), .ready(rdy_r), .address_in(ain_r), .nReady(nr_r), .valid(vld_r),
    .data_out(dout_r), .read_enable(re_r), .read_address(ra_r), .data_from_memory(dfm_r));
  read_memory_arbiter_pipelined #(.ARBITER_SIZE(2), .READ_LATENCY(3), .ROUND_ROBIN(1'b1)) u_3 (
    .clk(clk), .rst(rst), .pValid(pv_3), .ready(rdy_3), .address_in(ain_3), .nReady(nr_3), .valid(vld_3),
    .data_out(dout_3), .read_enable(re_3), .read_address(ra_3), .data_from_memory(dfm_3));
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h10) ? 32'hABCD : ((a ^ 32'h5A5A0000) + 32'd7);
  endfunction
  always @(posedge clk) begin
    mf_q <= mem(ra_f);
    mr_q <= mem(ra_r);
    m3_q[0] <= mem(ra_3);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign dfm_f = mf_q;
  assign dfm_r = mr_q;
  assign dfm_3 = m3_q[2];
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic mon(input int d, input int n, input logic [2:0] rdy, input logic [2:0] vld, input logic [2:0] nr,
                     input logic [95:0] ain, input logic [31:0] ra, input logic [95:0] dout);
    for (int i = 0; i < n; i++) begin
      if (rdy[i]) begin
        chk("read_address", ra, ain[i*32 +: 32]);
        sb[d*3+i].push_back(mem(ain[i*32 +: 32]));
      end
      if (vld[i] && nr[i]) begin
        chk("sb_depth", sb[d*3+i].size() > 0, 1);
        if (sb[d*3+i].size() > 0) chk("sb_data", dout[i*32 +: 32], sb[d*3+i].pop_front());
      end
    end
  endtask
  always @(negedge clk) begin
    #2;
    mon(0, 3, rdy_f, vld_f, nr_f, ain_f, ra_f, dout_f);
    mon(1, 3, rdy_r, vld_r, nr_r, ain_r, ra_r, dout_r);
    mon(2, 2, {1'b0, rdy_3}, {1'b0, vld_3}, {1'b0, nr_3}, {32'h0, ain_3}, ra_3, {32'h0, dout_3});
  end
  initial begin
    pv_f = 3'b111; pv_r = 3'b111; pv_3 = 2'b11;
    ain_f = {32'h108, 32'h104, 32'h100};
    ain_r = {32'h208, 32'h204, 32'h200};
    ain_3 = {32'h0, 32'h10};
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready_f", rdy_f, 0);
    chk("rst_re_f", re_f, 0);
    chk("rst_ra_f", ra_f, 0);
    chk("rst_valid_f", vld_f, 0);
    chk("rst_dout_f", dout_f, 0);
    chk("rst_ready_r", rdy_r, 0);
    chk("rst_ready_3", rdy_3, 0);
    chk("rst_valid_3", vld_3, 0);
    @(negedge clk);
    rst = 1'b0;
    pv_3 = 2'b00;
    nr_f = 3'b111;
    nr_r = 3'b111;
    nr_3 = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fix_grant", rdy_f, (k % 2) ? 2 : 1);
      chk("rr_grant", rdy_r, 1 << (k % 3));
      chk("rr_valid", vld_r, (k >= 2) ? (1 << ((k - 2) % 3)) : 0);
      @(negedge clk);
    end
    pv_f = 3'b000;
    pv_r = 3'b000;
    repeat (4) @(negedge clk);
    pv_3 = 2'b01;
    #1;
    chk("l3_ready_t", rdy_3, 2'b01);
    chk("l3_ra_t", ra_3, 32'h10);
    chk("l3_re_t", re_3, 1);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      #1;
      chk("l3_ready_wait", rdy_3, 0);
      chk("l3_valid_wait", vld_3, 0);
    end
    @(negedge clk);
    pv_3 = 2'b00;
    #1;
    chk("l3_valid_t4", vld_3, 2'b01);
    chk("l3_data_t4", dout_3[31:0], 32'hABCD);
    @(negedge clk);
    #1;
    chk("l3_valid_t5", vld_3, 0);
    chk("l3_hold_t5", dout_3[31:0], 32'hABCD);
    @(negedge clk);
    pv_3 = 2'b01;
    nr_3 = 2'b10;
    ain_3 = {32'h30, 32'h20};
    #1;
    chk("bp_grant0", rdy_3, 2'b01);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      #1;
      chk("bp_pending", rdy_3, 0);
    end
    @(negedge clk);
    pv_3 = 2'b11;
    #1;
    chk("bp_other_port", rdy_3, 2'b10);
    chk("bp_valid0", vld_3[0], 1);
    chk("bp_data0", dout_3[31:0], mem(32'h20));
    @(negedge clk);
    pv_3 = 2'b01;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("bp_blocked", rdy_3, 0);
      chk("bp_valid_hold", vld_3[0], 1);
      chk("bp_data_hold", dout_3[31:0], mem(32'h20));
      @(negedge clk);
    end
    nr_3 = 2'b11;
    #1;
    chk("bp_release", rdy_3, 2'b01);
    @(negedge clk);
    pv_3 = 2'b00;
    repeat (6) @(negedge clk);
    pv_3 = 2'b10;
    ain_3 = {32'h50, 32'h40};
    #1;
    chk("mr_grant1", rdy_3, 2'b10);
    @(negedge clk);
    pv_3 = 2'b00;
    rst = 1'b1;
    for (int q = 0; q < 9; q++) sb[q].delete();
    #1;
    chk("mr_valid_rst", vld_3, 0);
    chk("mr_ready_rst", rdy_3, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("mr_valid_after", vld_3, 0);
      @(negedge clk);
    end
    pv_3 = 2'b11;
    #1;
    chk("mr_first_grant", rdy_3, 2'b01);
    @(negedge clk);
    #1;
    chk("mr_second_grant", rdy_3, 2'b10);
    @(negedge clk);
    pv_3 = 2'b00;
    repeat (6) @(negedge clk);
    pv_f = 3'b110;
    ain_f = {32'h88, 32'h44, 32'h0};
    #1;
    chk("fx_ready", rdy_f, 3'b010);
    chk("fx_ra", ra_f, 32'h44);
    chk("fx_re", re_f, 1);
    @(negedge clk);
    pv_f = 3'b000;
    repeat (6) @(negedge clk);
    for (int q = 0; q < 9; q++) chk("sb_empty", sb[q].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
